// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and fetch stage.
package imem_loader_pkg;

   localparam int IMEM_ADDR_W = 17;

   typedef enum logic [1:0] {
      LD_LEN,
      LD_DATA,
      LD_DONE
   } ld_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Fetch read port plus UART byte stream and load status, bundled for the loader.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W
) ();

   logic [ADDR_W-1:0] inst_addr;
   logic [31:0]       inst_data;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   modport master (
      output inst_addr, rx_valid, rx_data,
      input  inst_data, load_done, load_err, words_loaded
   );

   modport slave (
      input  inst_addr, rx_valid, rx_data,
      output inst_data, load_done, load_err, words_loaded
   );

endinterface

// File: rtl/imem_loader_bram.sv
// Simple dual-port instruction RAM: one write port, one synchronous read-first read port.
module imem_bram #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem [DEPTH];

   // Read and write share one process so a same-address collision returns the old word.
   always_ff @(posedge clk) begin
      rdata_o <= mem[raddr_i];
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory responder with boot-time loader: length word, then big-endian data words.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DEPTH  = 1 << ADDR_W
) (
   input logic         clk,
   input logic         rstn,
   imem_loader_if.slave bus
);

   localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0]     DEPTH32 = 32'(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

   ld_state_t       state_q, state_d;
   logic [23:0]     sh_q, sh_d;
   logic [1:0]      bcnt_q, bcnt_d;
   logic [ADDR_W:0] n_q, n_d;
   logic [ADDR_W:0] wcnt_q, wcnt_d;
   logic [ADDR_W:0] wcnt_inc;
   logic            err_q, err_d;
   logic            done_q, done_d;
   logic            we;
   logic            last_byte;
   logic [31:0]     word;

   // Only three bytes are stored; the fourth is taken straight from rx_data on its strobe.
   assign word      = {sh_q, bus.rx_data};
   assign last_byte = bus.rx_valid && (bcnt_q == 2'd3);
   assign wcnt_inc  = wcnt_q + (ADDR_W+1)'(1);

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      bcnt_d  = bcnt_q;
      n_d     = n_q;
      wcnt_d  = wcnt_q;
      err_d   = err_q;
      done_d  = done_q | (state_q == LD_DONE);
      we      = 1'b0;

      if (bus.rx_valid && (state_q != LD_DONE)) begin
         sh_d   = word[23:0];
         bcnt_d = bcnt_q + 2'd1;
      end

      unique case (state_q)
         LD_LEN: begin
            if (last_byte) begin
               if (word == '0) begin
                  state_d = LD_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = LD_DATA;
                  if (word > DEPTH32) begin
                     err_d = 1'b1;
                     n_d   = DEPTH_N;
                  end else begin
                     n_d = word[ADDR_W:0];
                  end
               end
            end
         end
         LD_DATA: begin
            if (last_byte) begin
               we     = 1'b1;
               wcnt_d = wcnt_inc;
               if (wcnt_inc == n_q) begin
                  state_d = LD_DONE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= LD_LEN;
         sh_q    <= '0;
         bcnt_q  <= '0;
         n_q     <= '0;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         bcnt_q  <= bcnt_d;
         n_q     <= n_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign bus.load_done    = done_q;
   assign bus.load_err     = err_q;
   assign bus.words_loaded = wcnt_q;

   imem_bram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_bram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (wcnt_q[AW-1:0]),
      .wdata_i (word),
      .raddr_i (bus.inst_addr[AW-1:0]),
      .rdata_o (bus.inst_data)
   );

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory responder for the fetch stage, with a boot-time program loader. It owns the instruction RAM and answers the fetch unit's `inst_addr` with `inst_data` at a fixed one-edge latency. Before the core runs, it accepts a byte stream from the UART receiver, assembles big-endian 32-bit words and writes them into the RAM from word address 0. It then raises `load_done`, which releases the core from reset.

## Interface
Parameters:
- `ADDR_W`, default 17: word-address width; must match `inst_addr` of fetch.
- `DEPTH`, default `1<<ADDR_W`: number of 32-bit words implemented.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: synchronous reset, active-low.
- `inst_addr` in `ADDR_W`: word address driven combinationally by fetch from its next PC.
- `inst_data` out 32: instruction word at the `inst_addr` sampled on the last posedge.
- `rx_valid` in 1: one-cycle strobe, `rx_data` holds a new byte.
- `rx_data` in 8: received byte.
- `load_done` out 1: program fully written; drives the core reset release.
- `load_err` out 1: sticky; declared length exceeded `DEPTH`.
- `words_loaded` out `ADDR_W+1`: count of words written, for debug LEDs.

## Operation
- State machine `LD_LEN` → `LD_DATA` → `LD_DONE`; reset enters `LD_LEN`.
- Bytes accumulate in a 32-bit shift register, MSB first (`sh <= {sh[23:0], rx_data}`), with a 2-bit byte counter.
- `LD_LEN`: the first 4 bytes form word count N (unsigned 32-bit).
  - On the 4th byte, if N == 0 go to `LD_DONE`; otherwise go to `LD_DATA`.
  - If N > `DEPTH`, set `load_err` and clamp N to `DEPTH`.
- `LD_DATA`: every 4th byte writes the assembled word to `mem[waddr]`, then increments `waddr`.
  - When `waddr+1 == N`, go to `LD_DONE`.
- Bytes in excess of the clamped N are ignored in `LD_DONE`.
- `LD_DONE`: `load_done=1`. All further `rx_valid` are ignored until reset.
- Read path is always active, in every state: `inst_data <= mem[inst_addr]` on each posedge.
- Read/write to the same address in the same cycle is read-first: the old data is returned.
- RAM contents are never cleared by reset. A reset mid-load restarts at `LD_LEN` with the counters zeroed, and the next stream overwrites from address 0.
- `rx_valid` is accepted every cycle it is high; there is no backpressure.

## Timing
- Reset values: `load_done=0`, `load_err=0`, `words_loaded=0`, internal state `LD_LEN`, byte counter 0, `waddr` 0.
  - `inst_data` is not reset; it holds `mem[inst_addr]` from the first posedge.
- Read latency: `inst_addr` is presented before posedge k, and `inst_data` is valid after posedge k. Fetch samples it at the following negedge, so the read must settle within half a cycle.
- Write timing: the word is written on the posedge on which the 4th byte's `rx_valid` is high. `words_loaded` increments on that same edge.
- `load_done` rises on the posedge after the last word's write edge, and on the same edge as the N == 0 length completion. The core therefore sees all words written before it leaves reset.
- Back-to-back `rx_valid` on consecutive cycles is supported, giving at most one word write per 4 cycles.

## Structure
- Shared package (alongside `inst_set`): enum `ld_state_t` {`LD_LEN`, `LD_DATA`, `LD_DONE`}, and the `IMEM_ADDR_W=17` constant used by fetch and this block.
- Sub-module `imem_bram`: simple dual-port RAM with one write port and one synchronous read-first read port, inferable as block RAM.
- The FSM, byte assembler and counters live in the top module.

## Test plan
- Length 2, bytes `8C 01 00 04 00 00 00 08` → `mem[0]=0x8C010004`, `mem[1]=0x00000008`, `load_done` rises one cycle after the 2nd write, `words_loaded=2`.
- Length 0 → `load_done` rises on the 4th length byte's edge, no writes, `load_err=0`.
- `DEPTH=16`, length 20, 80 data bytes → 16 words written, `load_err=1`, `load_done=1`, and `mem[0]` is not overwritten by the extra bytes.
- After load, sweep `inst_addr` 0,1,0 on successive posedges → `inst_data` matches each word one edge later and is stable at every negedge.
- Same-cycle write to addr 3 with `inst_addr=3` → `inst_data` shows the old value, and the new value appears on the next read.
- Reset asserted after 6 of 12 bytes, then a full 3-word stream → state restarts, words land at 0..2, `words_loaded=3`.
